// File: rtl/data_access_pkg.sv
// Shared types for the data access unit: access sizes, FSM states and the alignment rule.
package data_access_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_t;

   // True when the access must be rejected without a memory cycle.
   function automatic logic access_err(input size_t size, input logic [1:0] off);
      logic err;
      unique case (size)
         SIZE_BYTE: err = 1'b0;
         SIZE_HALF: err = off[0];
         SIZE_WORD: err = (off != 2'b00);
         default:   err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane steering: extracts/extends load lanes and merges sub-word store data.
module byte_lane_unit
   import data_access_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  size_t       size,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [1:0]  byte_lane;
   logic        half_lane;
   logic [4:0]  byte_pos;
   logic [4:0]  half_pos;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Physical lane number, lane 0 being bits [7:0]; big-endian mirrors the address.
   assign byte_lane = BIG_ENDIAN ? ~addr : addr;
   assign half_lane = BIG_ENDIAN ? ~addr[1] : addr[1];
   assign byte_pos  = {byte_lane, 3'b000};
   assign half_pos  = {half_lane, 4'b0000};

   assign byte_val = word[byte_pos +: 8];
   assign half_val = word[half_pos +: 16];

   always_comb begin
      load_val = word;
      unique case (size)
         SIZE_BYTE: load_val = {{24{sign_ext & byte_val[7]}}, byte_val};
         SIZE_HALF: load_val = {{16{sign_ext & half_val[15]}}, half_val};
         default:   load_val = word;
      endcase
   end

   always_comb begin
      store_word = word;
      unique case (size)
         SIZE_BYTE: store_word[byte_pos +: 8]  = wdata[7:0];
         SIZE_HALF: store_word[half_pos +: 16] = wdata[15:0];
         default:   store_word = wdata;
      endcase
   end

endmodule

// File: rtl/data_access_unit.sv
// CPU data access unit: turns byte/half/word loads and stores into word accesses on a
// byte-enable-less memory port, using read-modify-write for sub-word stores.
module data_access_unit
   import data_access_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic        cpu_write,
   input  size_t       cpu_size,
   input  logic        cpu_signed,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,
   output logic        cpu_done,
   output logic [31:0] cpu_rdata,
   output logic        cpu_addr_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_write,
   input  logic [31:0] mem_dout,
   input  logic        mem_busy
);

   state_t      state_q, state_d;
   logic        req_write_q;
   size_t       req_size_q;
   logic        req_signed_q;
   logic [31:0] req_addr_q;
   logic [31:0] req_wdata_q;
   logic        err_q;
   logic [31:0] rbuf_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic        req_err;
   logic [31:0] load_val;
   logic [31:0] store_word;

   assign accept  = (state_q == IDLE) && cpu_req;
   assign req_err = access_err(cpu_size, cpu_addr[1:0]);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (req_err) begin
                  state_d = RESP;
               end else if (cpu_write && (cpu_size == SIZE_WORD)) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (!mem_busy) begin
               state_d = req_write_q ? WR : RESP;
            end
         end
         WR: begin
            if (!mem_busy) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request registers only load in IDLE, so memory sees a stable address/data all access long.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_write_q  <= 1'b0;
         req_size_q   <= SIZE_BYTE;
         req_signed_q <= 1'b0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         err_q        <= 1'b0;
      end else if (accept) begin
         req_write_q  <= cpu_write;
         req_size_q   <= cpu_size;
         req_signed_q <= cpu_signed;
         req_addr_q   <= cpu_addr;
         req_wdata_q  <= cpu_wdata;
         err_q        <= req_err;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rbuf_q  <= '0;
         rdata_q <= '0;
      end else begin
         if ((state_q == RD) && !mem_busy) begin
            rbuf_q <= mem_dout;
         end
         if (state_q == RESP) begin
            rdata_q <= cpu_rdata;
         end
      end
   end

   byte_lane_unit #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_byte_lane_unit (
      .word       (rbuf_q),
      .addr       (req_addr_q[1:0]),
      .size       (req_size_q),
      .sign_ext   (req_signed_q),
      .wdata      (req_wdata_q),
      .load_val   (load_val),
      .store_word (store_word)
   );

   assign cpu_ready    = (state_q == IDLE);
   assign cpu_done     = (state_q == RESP);
   assign cpu_addr_err = cpu_done && err_q;
   // A successful load presents the fresh lane during RESP; everything else holds the last result.
   assign cpu_rdata    = (cpu_done && !req_write_q && !err_q) ? load_val : rdata_q;

   assign mem_addr  = {req_addr_q[31:2], 2'b00};
   assign mem_write = (state_q == WR);
   assign mem_din   = mem_write ? store_word : '0;

endmodule

// File: tb/tb_data_access_unit.sv
// Self-checking bench for data_access_unit: little- and big-endian instances share stimulus
// and a word memory; a transaction-level model predicts latency, write data and load results.
module tb_data_access_unit;
   import data_access_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req;
   logic        cpu_write;
   size_t       cpu_size;
   logic        cpu_signed;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        mem_busy;

   logic        ready_le, done_le, err_le, mem_write_le;
   logic [31:0] rdata_le, mem_addr_le, mem_din_le, mem_dout_le;
   logic        ready_be, done_be, err_be, mem_write_be;
   logic [31:0] rdata_be, mem_addr_be, mem_din_be, mem_dout_be;

   logic [31:0] mem [16];
   logic [31:0] model_mem [16];
   logic [31:0] exp_rdata_le, exp_rdata_be;
   bit          busy_q[$];
   bit          rand_busy;
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   data_access_unit #(.BIG_ENDIAN(1'b0)) dut_le (
      .clk (clk), .reset_n (reset_n), .cpu_req (cpu_req), .cpu_write (cpu_write),
      .cpu_size (cpu_size), .cpu_signed (cpu_signed), .cpu_addr (cpu_addr),
      .cpu_wdata (cpu_wdata), .cpu_ready (ready_le), .cpu_done (done_le),
      .cpu_rdata (rdata_le), .cpu_addr_err (err_le), .mem_addr (mem_addr_le),
      .mem_din (mem_din_le), .mem_write (mem_write_le), .mem_dout (mem_dout_le),
      .mem_busy (mem_busy)
   );

   data_access_unit #(.BIG_ENDIAN(1'b1)) dut_be (
      .clk (clk), .reset_n (reset_n), .cpu_req (cpu_req), .cpu_write (cpu_write),
      .cpu_size (cpu_size), .cpu_signed (cpu_signed), .cpu_addr (cpu_addr),
      .cpu_wdata (cpu_wdata), .cpu_ready (ready_be), .cpu_done (done_be),
      .cpu_rdata (rdata_be), .cpu_addr_err (err_be), .mem_addr (mem_addr_be),
      .mem_din (mem_din_be), .mem_write (mem_write_be), .mem_dout (mem_dout_be),
      .mem_busy (mem_busy)
   );

   // Only the little-endian instance writes; the big-endian one is checked on its loads.
   assign mem_dout_le = mem[mem_addr_le[5:2]];
   assign mem_dout_be = mem[mem_addr_be[5:2]];

   always @(posedge clk) begin
      if (mem_write_le && !mem_busy) mem[mem_addr_le[5:2]] <= mem_din_le;
   end

   function automatic logic [31:0] init_word(input int i);
      return (i == 4) ? 32'h8899_AABB : (32'h1357_9BDF ^ (32'h0101_0101 * i));
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
   end

   function automatic logic [31:0] lane_load(input logic [31:0] w, input int off, input int sz,
                                             input bit sgn, input bit be);
      logic [31:0] v;
      if (sz == 0) begin
         v = (w >> ((be ? 3 - off : off) * 8)) & 32'h0000_00FF;
         if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
         v = (w >> ((be ? 2 - off : off) * 8)) & 32'h0000_FFFF;
         if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input int off, input int sz,
                                              input logic [31:0] wd);
      logic [31:0] mask;
      int          sh;
      if (sz == 2) return wd;
      sh   = off * 8;
      mask = (sz == 0) ? (32'h0000_00FF << sh) : (32'h0000_FFFF << sh);
      return (w & ~mask) | ((wd << sh) & mask);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // Called at #1 after a rising edge; returns at #1 after the edge that leaves RESP.
   task automatic do_txn(input bit wr, input int sz, input bit sgn, input logic [31:0] addr,
                         input logic [31:0] wd, input int exp_lat);
      bit          err;
      bit          busy;
      bit          done_seen;
      int          ph[$];
      int          idx;
      int          off;
      int          cyc;
      int          t;
      logic [31:0] exp_din;
      idx = int'(addr[5:2]);
      off = int'(addr[1:0]);
      t = 0;
      while (!ready_le && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!ready_le) check("ready_timeout", 32'd0, 32'd1);
      cpu_req    = 1'b1;
      cpu_write  = wr;
      cpu_size   = size_t'(sz);
      cpu_signed = sgn;
      cpu_addr   = addr;
      cpu_wdata  = wd;
      mem_busy   = 1'b0;
      @(posedge clk);
      #1;
      cpu_req   = 1'b0;
      cpu_addr  = $urandom();
      cpu_wdata = $urandom();
      err = (sz == 3) || (sz == 2 && off != 0) || (sz == 1 && (off % 2) != 0);
      if (!err) begin
         if (!wr) ph.push_back(1);
         else if (sz == 2) ph.push_back(2);
         else begin
            ph.push_back(1);
            ph.push_back(2);
         end
      end
      cyc = 1;
      done_seen = 1'b0;
      while (cyc <= 40 && !done_seen) begin
         if (busy_q.size() > 0) busy = busy_q.pop_front();
         else busy = rand_busy && (ph.size() > 0) && ($urandom_range(0, 3) == 0);
         mem_busy = busy;
         @(negedge clk);
         if (ph.size() == 0) begin
            done_seen = 1'b1;
            if (!wr && !err) begin
               exp_rdata_le = lane_load(model_mem[idx], off, sz, sgn, 1'b0);
               exp_rdata_be = lane_load(model_mem[idx], off, sz, sgn, 1'b1);
            end
            check("done", done_le, 1'b1);
            check("done_be", done_be, 1'b1);
            check("addr_err", err_le, err);
            check("rdata_le", rdata_le, exp_rdata_le);
            check("rdata_be", rdata_be, exp_rdata_be);
            check("no_write_in_resp", mem_write_le, 1'b0);
            if (exp_lat >= 0) check("latency", cyc, exp_lat);
         end else begin
            check("done_early", done_le, 1'b0);
            check("mem_write", mem_write_le, ph[0] == 2);
            check("mem_addr", mem_addr_le, {addr[31:2], 2'b00});
            if (ph[0] == 2) begin
               exp_din = lane_merge(model_mem[idx], off, sz, wd);
               check("mem_din", mem_din_le, exp_din);
            end
            if (!busy) begin
               if (ph[0] == 2) model_mem[idx] = exp_din;
               void'(ph.pop_front());
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done_seen) check("done_timeout", 32'd0, 32'd1);
      mem_busy = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      cpu_req    = 1'b0;
      cpu_write  = 1'b0;
      cpu_size   = SIZE_BYTE;
      cpu_signed = 1'b0;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      mem_busy   = 1'b0;
      rand_busy  = 1'b0;
      exp_rdata_le = '0;
      exp_rdata_be = '0;
      for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);

      #2;
      check("rst_ready", ready_le, 1'b1);
      check("rst_done", done_le, 1'b0);
      check("rst_rdata", rdata_le, 32'h0);
      check("rst_err", err_le, 1'b0);
      check("rst_mem_write", mem_write_le, 1'b0);
      check("rst_mem_addr", mem_addr_le, 32'h0);
      check("rst_mem_din", mem_din_le, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Loads of 0x8899_AABB
      do_txn(1'b0, 0, 1'b1, 32'h5001_0011, 32'h0, 2);
      check("ld_byte_s", rdata_le, 32'hFFFF_FFAA);
      do_txn(1'b0, 0, 1'b0, 32'h5001_0011, 32'h0, 2);
      check("ld_byte_u", rdata_le, 32'h0000_00AA);
      do_txn(1'b0, 1, 1'b1, 32'h5001_0012, 32'h0, 2);
      check("ld_half_s", rdata_le, 32'hFFFF_8899);
      do_txn(1'b0, 0, 1'b0, 32'h5001_0010, 32'h0, 2);
      check("be_byte0", rdata_be, 32'h0000_0088);

      // Sub-word store then readback
      do_txn(1'b1, 0, 1'b0, 32'h5001_0012, 32'h0000_0055, 3);
      do_txn(1'b0, 2, 1'b0, 32'h5001_0010, 32'h0, 2);
      check("rmw_readback", rdata_le, 32'h8855_AABB);

      // Word store then readback
      do_txn(1'b1, 2, 1'b0, 32'hA000_0004, 32'hDEAD_BEEF, 2);
      do_txn(1'b0, 2, 1'b0, 32'hA000_0004, 32'h0, 2);
      check("word_readback", rdata_le, 32'hDEAD_BEEF);

      // Misaligned and reserved size
      do_txn(1'b0, 2, 1'b0, 32'h5001_0002, 32'h0, 1);
      do_txn(1'b0, 1, 1'b0, 32'h5001_0001, 32'h0, 1);
      do_txn(1'b1, 3, 1'b0, 32'h5001_0010, 32'h1234_5678, 1);
      do_txn(1'b1, 1, 1'b0, 32'h5001_0013, 32'h1234_5678, 1);

      // Stalls: 3 cycles in RD, 2 in WR
      busy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      do_txn(1'b1, 0, 1'b0, 32'h5001_0011, 32'h0000_00C3, 8);

      // Randomized traffic with random stalls
      rand_busy = 1'b1;
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         logic [31:0] d;
         a = $urandom();
         d = $urandom();
         do_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, d, -1);
      end
      rand_busy = 1'b0;

      // Reset while a byte store is stalled in WR
      cpu_req    = 1'b1;
      cpu_write  = 1'b1;
      cpu_size   = SIZE_BYTE;
      cpu_signed = 1'b0;
      cpu_addr   = 32'h5001_0013;
      cpu_wdata  = 32'h0000_0077;
      mem_busy   = 1'b0;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      @(posedge clk);
      #1;
      mem_busy = 1'b1;
      @(negedge clk);
      check("wr_before_rst", mem_write_le, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_mem_write", mem_write_le, 1'b0);
      check("arst_ready", ready_le, 1'b1);
      check("arst_done", done_le, 1'b0);
      check("arst_rdata", rdata_le, 32'h0);
      check("arst_rdata_be", rdata_be, 32'h0);
      check("arst_mem_din", mem_din_le, 32'h0);
      exp_rdata_le = '0;
      exp_rdata_be = '0;
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      mem_busy = 1'b0;
      do_txn(1'b0, 2, 1'b0, 32'h5001_0010, 32'h0, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_access_unit.md
Name: data_access_unit

Overview:
- Sits between the CPU memory stage and the data port of the unified memory, which is word-wide with no byte enables.
- Converts CPU byte, halfword and word loads and stores into word-aligned accesses on that port.
- Sign- or zero-extends load data.
- Performs read-modify-write for sub-word stores.
- Flags misaligned accesses without touching memory.

Parameters:
- BIG_ENDIAN, 0, byte-lane order. 0: byte at addr[1:0]=0 is bits [7:0]. 1: byte at addr[1:0]=0 is bits [31:24].

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  asynchronous reset, active-low
- cpu_req  input  1  request strobe; sampled only while cpu_ready=1
- cpu_write  input  1  1=store, 0=load
- cpu_size  input  2  access size (package enum)
- cpu_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data, right-justified
- cpu_ready  output  1  unit idle, can accept a request
- cpu_done  output  1  one-cycle completion pulse
- cpu_rdata  output  32  load result; valid while cpu_done=1, held until next completion
- cpu_addr_err  output  1  valid with cpu_done; 1 = misaligned or reserved size
- mem_addr  output  32  word address to memory, {addr[31:2],2'b00}
- mem_din  output  32  write data to memory
- mem_write  output  1  memory write enable
- mem_dout  input  32  memory read data, combinational from mem_addr
- mem_busy  input  1  memory stall; while 1, no read is captured and no write counts as done

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset (async, any state): state=IDLE; cpu_ready=1; cpu_done=0; cpu_rdata=0; cpu_addr_err=0; mem_write=0; mem_addr=0; mem_din=0. A reset mid-operation abandons the access, and mem_write drops immediately.
- IDLE: cpu_ready=1.
  - On cpu_req, latch write, size, signed, addr and wdata into request registers.
  - Error condition, checked first: size=WORD with addr[1:0]!=0, size=HALF with addr[0]!=0, or size=RSVD. Go to RESP with err=1; no memory cycle.
  - Load, or sub-word store: go to RD.
  - Word store: go to WR.
- RD: mem_addr=latched word address, mem_write=0.
  - While mem_busy=1: stay.
  - When mem_busy=0, capture mem_dout into the read buffer. Load goes to RESP; sub-word store goes to WR.
- WR: mem_write=1 and mem_din held stable while in state.
  - Word store: mem_din=wdata.
  - Sub-word store: mem_din = read buffer with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0]. Other lanes are unchanged.
  - While mem_busy=1: stay. When mem_busy=0, the write completes that edge; go to RESP.
- RESP: cpu_done=1 for exactly one cycle, cpu_ready=0, then IDLE.
  - Load: cpu_rdata = extracted lane, extended per the latched cpu_signed.
  - Store or error: cpu_rdata unchanged from the previous completion.
  - cpu_addr_err = latched error flag.
- Minimum latency, with mem_busy=0 throughout, from the request cycle to the cpu_done cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
  - Each cycle of mem_busy=1 adds one cycle.
- cpu_req while cpu_ready=0 is ignored; the CPU holds the request until it sees ready.
- The request registers are not updated outside IDLE, so the address and data seen by memory are stable for the whole access.
- The store RMW is non-atomic. This is acceptable in a single-master system.

Decomposition:
- Package data_access_pkg contains:
  - the size_t enum: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_RSVD=2'b11;
  - the state_t enum: IDLE, RD, WR, RESP.
- Sub-module byte_lane_unit, purely combinational, parameterised by BIG_ENDIAN:
  - inputs: word, addr[1:0], size, signed, wdata;
  - outputs: extracted load value and merged store word.
- The top level holds the FSM and registers only.

Test Plan:
- Word at 0x5001_0010 = 0x8899_AABB, LE. Load byte signed @0x5001_0011 -> rdata=0xFFFF_FFAA. Unsigned byte -> 0x0000_00AA. Half signed @0x5001_0012 -> 0xFFFF_8899. done 2 cycles after req.
- Same word, store byte 0x55 @0x5001_0012 -> exactly one mem_write cycle with mem_din=0x8855_AABB. done 3 cycles after req. A readback word load returns 0x8855_AABB.
- Word store 0xDEAD_BEEF @0xA000_0004 -> one write cycle only, no RD state visited. mem_addr=0xA000_0004. Readback matches.
- Misaligned: word @0x5001_0002, half @0x5001_0001, and size=2'b11 -> each gives done with addr_err=1 one cycle after req; mem_write never asserted.
- mem_busy held high 3 cycles during RD, then 2 cycles during WR of a byte store -> mem_din stable across the WR stall. done at 3+5=8 cycles.
- reset_n pulsed low while in WR -> mem_write falls the same cycle, and cpu_ready=1, cpu_done=0, cpu_rdata=0 with no clock edge. BIG_ENDIAN=1: byte load @addr[1:0]=0 of 0x8899_AABB unsigned -> 0x0000_0088.
